// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key tokens, FSM state
// encoding and error codes.
package calc_pkg;

   // Reserved keypad tokens; every other code is an ordinary token.
   localparam logic [7:0] KEY_EVAL  = 8'hEE;
   localparam logic [7:0] KEY_CLEAR = 8'hCC;
   localparam logic [7:0] KEY_BKSP  = 8'hBB;
   localparam logic [7:0] KEY_DOT   = 8'hDD;

   typedef enum logic [2:0] {
      ST_EDIT     = 3'd0,
      ST_BUILD    = 3'd1,
      ST_CONVERT  = 3'd2,
      ST_EVALUATE = 3'd3,
      ST_SHOW     = 3'd4,
      ST_ERROR    = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_OVERFLOW = 3'd1,
      ERR_EMPTY    = 3'd2,
      ERR_EVAL     = 3'd3,
      ERR_TIMEOUT  = 3'd4
   } err_e;

   // True for the three states that wait on an external engine.
   function automatic logic is_stage(input logic [2:0] s);
      return (s == ST_BUILD) || (s == ST_CONVERT) || (s == ST_EVALUATE);
   endfunction

endpackage

// File: rtl/calc_stage_timer.sv
// Per-stage watchdog: counts cycles spent in the current stage and flags
// the last permitted cycle. Only instantiated when CALC_SEQ_TIMEOUT_EN is set.
module calc_stage_timer #(
   parameter int TIMEOUT = 1023
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Expired during the TIMEOUT-th cycle of the stage, so the owner leaves
   // after exactly TIMEOUT cycles.
   assign expired = enable && (cnt_q == LAST);

   // Next count: restart on stage change, otherwise advance while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: collects keypad tokens, then drives the number
// builder, postfix converter and evaluator in turn using one-cycle start
// pulses. Optional per-stage watchdog enabled by CALC_SEQ_TIMEOUT_EN.
//
// Handshake: each *_start / nb_eval is a registered one-cycle pulse issued
// only on entry to its stage; the matching *_done is a one-cycle pulse that
// is honoured only while the FSM is in the owning stage and ignored elsewhere.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DEPTH   = 10,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         key_valid,
   input  logic [WIDTH-1:0]             key_code,
   output logic [$clog2(DEPTH+1)-1:0]   tok_size,
   output logic [WIDTH-1:0]             tok_mem [DEPTH],
   output logic                         nb_eval,
   input  logic                         nb_done,
   output logic                         pf_start,
   input  logic                         pf_done,
   output logic                         ev_start,
   input  logic                         ev_done,
   input  logic                         ev_error,
   output logic                         busy,
   output logic                         result_valid,
   output logic                         error,
   output logic [2:0]                   err_code,
   output logic [2:0]                   state_dbg
);

   localparam int SW = $clog2(DEPTH + 1);

   localparam logic [2:0] S_EDIT     = ST_EDIT;
   localparam logic [2:0] S_BUILD    = ST_BUILD;
   localparam logic [2:0] S_CONVERT  = ST_CONVERT;
   localparam logic [2:0] S_EVALUATE = ST_EVALUATE;
   localparam logic [2:0] S_SHOW     = ST_SHOW;
   localparam logic [2:0] S_ERROR    = ST_ERROR;

   localparam logic [WIDTH-1:0] K_EVAL  = WIDTH'(KEY_EVAL);
   localparam logic [WIDTH-1:0] K_CLEAR = WIDTH'(KEY_CLEAR);
   localparam logic [WIDTH-1:0] K_BKSP  = WIDTH'(KEY_BKSP);

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] tok_mem_q [DEPTH];
   logic [WIDTH-1:0] tok_mem_d [DEPTH];
   logic [SW-1:0]    tok_size_q, tok_size_d;
   logic [2:0]       err_q, err_d;
   logic             nb_eval_q, nb_eval_d;
   logic             pf_start_q, pf_start_d;
   logic             ev_start_q, ev_start_d;

   logic is_clear, is_eval, is_bksp, is_plain;
   logic stage_expired;

   assign is_clear = key_valid && (key_code == K_CLEAR);
   assign is_eval  = key_valid && (key_code == K_EVAL);
   assign is_bksp  = key_valid && (key_code == K_BKSP);
   assign is_plain = key_valid && !is_clear && !is_eval && !is_bksp;

`ifdef CALC_SEQ_TIMEOUT_EN
   logic timer_clear, timer_enable;

   // Restart the count whenever the state changes, so each stage gets a
   // fresh budget on entry.
   assign timer_clear  = (state_d != state_q);
   assign timer_enable = is_stage(state_q);

   calc_stage_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_stage_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (stage_expired)
   );
`else
   // Stages wait indefinitely; TIMEOUT has no effect in this build.
   assign stage_expired = 1'b0 & (TIMEOUT == 0);
`endif

   // Next-state, buffer and pulse logic. CLEAR overrides everything,
   // including a done pulse arriving in the same cycle.
   always_comb begin
      state_d    = state_q;
      tok_mem_d  = tok_mem_q;
      tok_size_d = tok_size_q;
      err_d      = err_q;
      nb_eval_d  = 1'b0;
      pf_start_d = 1'b0;
      ev_start_d = 1'b0;

      if (is_clear) begin
         for (int i = 0; i < DEPTH; i++) tok_mem_d[i] = '0;
         tok_size_d = '0;
         err_d      = ERR_NONE;
         state_d    = S_EDIT;
      end else begin
         case (state_q)
            S_EDIT: begin
               if (is_eval) begin
                  if (tok_size_q != '0) begin
                     nb_eval_d = 1'b1;
                     state_d   = S_BUILD;
                  end else begin
                     err_d   = ERR_EMPTY;
                     state_d = S_ERROR;
                  end
               end else if (is_bksp) begin
                  if (tok_size_q != '0) begin
                     for (int i = 0; i < DEPTH; i++) begin
                        if (SW'(i + 1) == tok_size_q) tok_mem_d[i] = '0;
                     end
                     tok_size_d = tok_size_q - SW'(1);
                  end
               end else if (is_plain) begin
                  if (tok_size_q < SW'(DEPTH)) begin
                     for (int i = 0; i < DEPTH; i++) begin
                        if (SW'(i) == tok_size_q) tok_mem_d[i] = key_code;
                     end
                     tok_size_d = tok_size_q + SW'(1);
                  end else begin
                     err_d   = ERR_OVERFLOW;
                     state_d = S_ERROR;
                  end
               end
            end
            S_BUILD: begin
               if (nb_done) begin
                  pf_start_d = 1'b1;
                  state_d    = S_CONVERT;
               end else if (stage_expired) begin
                  err_d   = ERR_TIMEOUT;
                  state_d = S_ERROR;
               end
            end
            S_CONVERT: begin
               if (pf_done) begin
                  ev_start_d = 1'b1;
                  state_d    = S_EVALUATE;
               end else if (stage_expired) begin
                  err_d   = ERR_TIMEOUT;
                  state_d = S_ERROR;
               end
            end
            S_EVALUATE: begin
               if (ev_done) begin
                  if (ev_error) begin
                     err_d   = ERR_EVAL;
                     state_d = S_ERROR;
                  end else begin
                     state_d = S_SHOW;
                  end
               end else if (stage_expired) begin
                  err_d   = ERR_TIMEOUT;
                  state_d = S_ERROR;
               end
            end
            S_SHOW: begin
               // A new ordinary key starts a fresh expression with that key.
               if (is_plain) begin
                  for (int i = 0; i < DEPTH; i++) tok_mem_d[i] = '0;
                  tok_mem_d[0] = key_code;
                  tok_size_d   = SW'(1);
                  state_d      = S_EDIT;
               end
            end
            S_ERROR: begin
               state_d = S_ERROR;
            end
            default: begin
               state_d = S_EDIT;
            end
         endcase
      end
   end

   // State, buffer and pulse registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_EDIT;
         for (int i = 0; i < DEPTH; i++) tok_mem_q[i] <= '0;
         tok_size_q <= '0;
         err_q      <= ERR_NONE;
         nb_eval_q  <= 1'b0;
         pf_start_q <= 1'b0;
         ev_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tok_mem_q  <= tok_mem_d;
         tok_size_q <= tok_size_d;
         err_q      <= err_d;
         nb_eval_q  <= nb_eval_d;
         pf_start_q <= pf_start_d;
         ev_start_q <= ev_start_d;
      end
   end

   assign tok_mem      = tok_mem_q;
   assign tok_size     = tok_size_q;
   assign nb_eval      = nb_eval_q;
   assign pf_start     = pf_start_q;
   assign ev_start     = ev_start_q;
   assign busy         = is_stage(state_q);
   assign result_valid = (state_q == S_SHOW);
   assign error        = (state_q == S_ERROR);
   assign err_code     = err_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer. Inputs change and outputs are sampled
// on the falling clock edge; a token queue holds the expected buffer.
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int DEPTH = 10;
   localparam int WIDTH = 8;

   logic             clock;
   logic             reset;
   logic             key_valid;
   logic [WIDTH-1:0] key_code;
   logic [3:0]       tok_size;
   logic [WIDTH-1:0] tok_mem [DEPTH];
   logic             nb_eval, nb_done;
   logic             pf_start, pf_done;
   logic             ev_start, ev_done, ev_error;
   logic             busy, result_valid, error;
   logic [2:0]       err_code;
   logic [2:0]       state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] exp_q[$];

   calc_sequencer #(
      .DEPTH   (DEPTH),
      .WIDTH   (WIDTH),
      .TIMEOUT (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .tok_size     (tok_size),
      .tok_mem      (tok_mem),
      .nb_eval      (nb_eval),
      .nb_done      (nb_done),
      .pf_start     (pf_start),
      .pf_done      (pf_done),
      .ev_start     (ev_start),
      .ev_done      (ev_done),
      .ev_error     (ev_error),
      .busy         (busy),
      .result_valid (result_valid),
      .error        (error),
      .err_code     (err_code),
      .state_dbg    (state_dbg)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Compare tok_size and every tok_mem entry against the expected queue.
   task automatic check_buffer(input string tag);
      logic [WIDTH-1:0] e;
      check_eq({tag, ".size"}, 32'(tok_size), 32'(exp_q.size()));
      for (int i = 0; i < DEPTH; i++) begin
         e = (i < exp_q.size()) ? exp_q[i] : '0;
         check_eq($sformatf("%s.mem%0d", tag, i), 32'(tok_mem[i]), 32'(e));
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // One-cycle key strobe; returns on the falling edge after the DUT took it.
   task automatic press(input logic [WIDTH-1:0] k);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clock);
      key_valid = 1'b0;
      key_code  = '0;
   endtask

   task automatic press_tok(input logic [WIDTH-1:0] k);
      press(k);
      exp_q.push_back(k);
   endtask

   // which: 0 nb_done, 1 pf_done, 2 ev_done.
   task automatic fire(input int which, input logic err);
      case (which)
         0: nb_done = 1'b1;
         1: pf_done = 1'b1;
         default: begin ev_done = 1'b1; ev_error = err; end
      endcase
      @(negedge clock);
      nb_done  = 1'b0;
      pf_done  = 1'b0;
      ev_done  = 1'b0;
      ev_error = 1'b0;
   endtask

   initial begin
      int cnt;

      reset = 1'b1; key_valid = 1'b0; key_code = '0;
      nb_done = 1'b0; pf_done = 1'b0; ev_done = 1'b0; ev_error = 1'b0;
      step(3);
      reset = 1'b0;

      // Reset state
      check_eq("rst.state", 32'(state_dbg), 32'(ST_EDIT));
      check_buffer("rst");
      check_eq("rst.pulses", {29'd0, nb_eval, pf_start, ev_start}, 32'd0);
      check_eq("rst.flags", {29'd0, busy, result_valid, error}, 32'd0);
      check_eq("rst.err", 32'(err_code), 32'd0);

      // Full pass: 1 2 . 5 A then EVAL
      press_tok(8'h01); press_tok(8'h02); press_tok(8'hDD);
      press_tok(8'h05); press_tok(8'h0A);
      check_buffer("fill5");
      press(8'hEE);
      check_eq("eval.nb_eval", 32'(nb_eval), 32'd1);
      check_eq("eval.state", 32'(state_dbg), 32'(ST_BUILD));
      check_eq("eval.busy", 32'(busy), 32'd1);
      step(1);
      check_eq("eval.nb_eval_low", 32'(nb_eval), 32'd0);
      press(8'h03);
      check_buffer("busy_key");
      fire(1, 1'b0);
      check_eq("stray_pf.state", 32'(state_dbg), 32'(ST_BUILD));
      check_eq("stray_pf.ev_start", 32'(ev_start), 32'd0);
      fire(0, 1'b0);
      check_eq("nb_done.pf_start", 32'(pf_start), 32'd1);
      check_eq("nb_done.state", 32'(state_dbg), 32'(ST_CONVERT));
      step(1);
      check_eq("pf_start_low", 32'(pf_start), 32'd0);
      fire(1, 1'b0);
      check_eq("pf_done.ev_start", 32'(ev_start), 32'd1);
      check_eq("pf_done.state", 32'(state_dbg), 32'(ST_EVALUATE));
      step(1);
      check_eq("ev_start_low", 32'(ev_start), 32'd0);
      fire(2, 1'b0);
      check_eq("ev_done.state", 32'(state_dbg), 32'(ST_SHOW));
      check_eq("ev_done.result_valid", 32'(result_valid), 32'd1);
      check_eq("ev_done.busy", 32'(busy), 32'd0);

      // SHOW ignores EVAL and BKSP; an ordinary key restarts the buffer
      press(8'hEE);
      check_eq("show_eval.state", 32'(state_dbg), 32'(ST_SHOW));
      check_eq("show_eval.nb_eval", 32'(nb_eval), 32'd0);
      press(8'hBB);
      check_buffer("show_bksp");
      press(8'h09);
      exp_q.delete();
      exp_q.push_back(8'h09);
      check_eq("show_key.state", 32'(state_dbg), 32'(ST_EDIT));
      check_eq("show_key.result_valid", 32'(result_valid), 32'd0);
      check_buffer("show_key");
      fire(2, 1'b0);
      check_eq("stray_ev.state", 32'(state_dbg), 32'(ST_EDIT));

      // Overflow on the eleventh key
      press(8'hCC);
      exp_q.delete();
      check_buffer("clear1");
      for (int i = 0; i < DEPTH; i++) press_tok(8'h10 + 8'(i));
      check_buffer("full");
      check_eq("full.state", 32'(state_dbg), 32'(ST_EDIT));
      press(8'h2A);
      check_eq("ovf.state", 32'(state_dbg), 32'(ST_ERROR));
      check_eq("ovf.err", 32'(err_code), 32'd1);
      check_eq("ovf.error", 32'(error), 32'd1);
      check_buffer("ovf");
      press(8'hBB);
      check_buffer("err_bksp");
      press(8'hCC);
      exp_q.delete();
      check_eq("ovf_clr.state", 32'(state_dbg), 32'(ST_EDIT));
      check_eq("ovf_clr.err", 32'(err_code), 32'd0);
      check_buffer("ovf_clr");

      // EVAL on an empty buffer
      press(8'hEE);
      check_eq("empty.nb_eval", 32'(nb_eval), 32'd0);
      check_eq("empty.state", 32'(state_dbg), 32'(ST_ERROR));
      check_eq("empty.err", 32'(err_code), 32'd2);
      press(8'hCC);

      // Backspace
      press_tok(8'h07); press_tok(8'h08);
      press(8'hBB); void'(exp_q.pop_back());
      check_buffer("bksp1");
      press(8'hBB); void'(exp_q.pop_back());
      check_buffer("bksp2");
      press(8'hBB);
      check_buffer("bksp3");

      // Evaluator error
      press_tok(8'h04);
      press(8'hEE);
      fire(0, 1'b0);
      fire(1, 1'b0);
      fire(2, 1'b1);
      check_eq("everr.state", 32'(state_dbg), 32'(ST_ERROR));
      check_eq("everr.err", 32'(err_code), 32'd3);
      check_eq("everr.result_valid", 32'(result_valid), 32'd0);
      press(8'hCC);
      exp_q.delete();

      // CLEAR coincident with nb_done wins
      press_tok(8'h04);
      press(8'hEE);
      key_valid = 1'b1; key_code = 8'hCC; nb_done = 1'b1;
      @(negedge clock);
      key_valid = 1'b0; key_code = '0; nb_done = 1'b0;
      exp_q.delete();
      check_eq("clr_done.state", 32'(state_dbg), 32'(ST_EDIT));
      check_eq("clr_done.pf_start", 32'(pf_start), 32'd0);
      check_buffer("clr_done");
      step(1);
      check_eq("clr_done.pf_start_later", 32'(pf_start), 32'd0);

      // Ordinary key coincident with nb_done: key dropped, done taken
      press_tok(8'h06);
      press(8'hEE);
      key_valid = 1'b1; key_code = 8'h33; nb_done = 1'b1;
      @(negedge clock);
      key_valid = 1'b0; key_code = '0; nb_done = 1'b0;
      check_eq("key_done.state", 32'(state_dbg), 32'(ST_CONVERT));
      check_eq("key_done.pf_start", 32'(pf_start), 32'd1);
      check_buffer("key_done");

      // Reset in CONVERT with pf_done pending: no ev_start
      reset = 1'b1; pf_done = 1'b1;
      @(negedge clock);
      reset = 1'b0; pf_done = 1'b0;
      exp_q.delete();
      check_eq("rst_mid.state", 32'(state_dbg), 32'(ST_EDIT));
      check_eq("rst_mid.ev_start", 32'(ev_start), 32'd0);
      check_buffer("rst_mid");
      step(1);
      check_eq("rst_mid.ev_start_later", 32'(ev_start), 32'd0);

      // Watchdog / no watchdog in BUILD
      press_tok(8'h01);
      press(8'hEE);
      cnt = 0;
`ifdef CALC_SEQ_TIMEOUT_EN
      for (int i = 0; i < 20 && state_dbg == ST_BUILD; i++) begin
         cnt++;
         step(1);
      end
      check_eq("wd.cycles", 32'(cnt), 32'd8);
      check_eq("wd.state", 32'(state_dbg), 32'(ST_ERROR));
      check_eq("wd.err", 32'(err_code), 32'd4);
`else
      for (int i = 0; i < 100; i++) begin
         if (state_dbg == ST_BUILD) cnt++;
         step(1);
      end
      check_eq("nowd.cycles", 32'(cnt), 32'd100);
      check_eq("nowd.err", 32'(err_code), 32'd0);
`endif
      press(8'hCC);
      exp_q.delete();
      check_eq("final.state", 32'(state_dbg), 32'(ST_EDIT));
      check_buffer("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
